// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: one command becomes one INCR burst; write data streams in, read data streams out.
// Optional build macro AXI_MASTER_RLAST_CHECK_EN checks rlast against the requested beat count.
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ID_WIDTH-1:0]   axi_awid_o,
    output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
    output logic [LEN_WIDTH-1:0]  axi_awlen_o,
    output logic [2:0]            axi_awsize_o,
    output logic [1:0]            axi_awburst_o,
    output logic [1:0]            axi_awlock_o,
    output logic [3:0]            axi_awcache_o,
    output logic [2:0]            axi_awprot_o,
    output logic [3:0]            axi_awqos_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [DATA_WIDTH-1:0] axi_wdata_o,
    output logic [STRB_WIDTH-1:0] axi_wstrb_o,
    output logic                  axi_wlast_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    input  logic [ID_WIDTH-1:0]   axi_bid_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    output logic [ID_WIDTH-1:0]   axi_arid_o,
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    output logic [LEN_WIDTH-1:0]  axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic [1:0]            axi_arlock_o,
    output logic [3:0]            axi_arcache_o,
    output logic [2:0]            axi_arprot_o,
    output logic [3:0]            axi_arqos_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    input  logic [ID_WIDTH-1:0]   axi_rid_i,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o
);

    // state    | meaning
    // ST_IDLE  | waiting for a command, cmd_ready_o high
    // ST_AW    | write address presented
    // ST_W     | write beats streaming from wr_* to W
    // ST_B     | waiting for write response
    // ST_AR    | read address presented
    // ST_R     | read beats streaming from R to rd_*
    // ST_DRAIN | beat count reached without rlast; sinking leftover R beats
    typedef enum logic [2:0] {
        ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DRAIN
    } state_t;

    localparam int                    SZ        = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  acc_q, acc_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  last_beat;
    logic                  r_err;
    logic                  unused_ok;

    assign last_beat = (cnt_q == len_q);
    assign r_err     = (axi_rresp_i != 2'b00);
    assign unused_ok = ^{axi_bid_i, axi_rid_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        axi_awvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        axi_wlast_o   = 1'b0;
        wr_ready_o    = 1'b0;
        axi_bready_o  = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_rready_o  = 1'b0;
        rd_valid_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    addr_d  = cmd_addr_i & ADDR_MASK;
                    len_d   = cmd_len_i;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    state_d = cmd_we_i ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                axi_awvalid_o = 1'b1;
                if (axi_awready_i) state_d = ST_W;
            end
            ST_W: begin
                axi_wvalid_o = wr_valid_i;
                wr_ready_o   = axi_wready_i;
                axi_wlast_o  = last_beat;
                if (wr_valid_i && axi_wready_i) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (last_beat) state_d = ST_B;
                end
            end
            ST_B: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    done_d  = 1'b1;
                    err_d   = (axi_bresp_i != 2'b00);
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                axi_arvalid_o = 1'b1;
                if (axi_arready_i) state_d = ST_R;
            end
            ST_R: begin
                rd_valid_o   = axi_rvalid_i;
                axi_rready_o = rd_ready_i;
                if (axi_rvalid_i && rd_ready_i) begin
`ifdef AXI_MASTER_RLAST_CHECK_EN
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (axi_rlast_i || last_beat) begin
                        done_d  = 1'b1;
                        err_d   = acc_q | r_err | (axi_rlast_i != last_beat);
                        state_d = axi_rlast_i ? ST_IDLE : ST_DRAIN;
                    end else begin
                        acc_d = acc_q | r_err;
                    end
`else
                    acc_d = acc_q | r_err;
                    if (axi_rlast_i) begin
                        done_d  = 1'b1;
                        err_d   = acc_q | r_err;
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            ST_DRAIN: begin
                // Overlong burst: swallow beats without forwarding until the responder ends it.
                axi_rready_o = 1'b1;
                if (axi_rvalid_i && axi_rlast_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE) && !done_d;
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign axi_wdata_o   = wr_data_i;
    assign rd_data_o     = axi_rdata_i;
    assign axi_wstrb_o   = '1;

    assign axi_awid_o    = ID_WIDTH'(AXI_ID);
    assign axi_awaddr_o  = addr_q;
    assign axi_awlen_o   = len_q;
    assign axi_awsize_o  = 3'(SZ);
    assign axi_awburst_o = 2'b01;
    assign axi_awlock_o  = 2'b00;
    assign axi_awcache_o = 4'b0011;
    assign axi_awprot_o  = 3'b000;
    assign axi_awqos_o   = 4'b0000;

    assign axi_arid_o    = ID_WIDTH'(AXI_ID);
    assign axi_araddr_o  = addr_q;
    assign axi_arlen_o   = len_q;
    assign axi_arsize_o  = 3'(SZ);
    assign axi_arburst_o = 2'b01;
    assign axi_arlock_o  = 2'b00;
    assign axi_arcache_o = 4'b0011;
    assign axi_arprot_o  = 3'b000;
    assign axi_arqos_o   = 4'b0000;

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized scoreboard bench for axi_burst_master: tb AXI RAM responder, stream source/sink,
// and a word-array reference model that predicts read data, error flags and address-channel fields.
module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_ready_o;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready = 1'b0;
    logic        done_o, err_o;
    logic [7:0]  axi_awid_o, axi_arid_o;
    logic [15:0] axi_awaddr_o, axi_araddr_o;
    logic [7:0]  axi_awlen_o, axi_arlen_o;
    logic [2:0]  axi_awsize_o, axi_arsize_o, axi_awprot_o, axi_arprot_o;
    logic [1:0]  axi_awburst_o, axi_arburst_o, axi_awlock_o, axi_arlock_o;
    logic [3:0]  axi_awcache_o, axi_arcache_o, axi_awqos_o, axi_arqos_o;
    logic        axi_awvalid_o, axi_arvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o, axi_rready_o;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_awready_i = 1'b0, axi_arready_i = 1'b0, axi_wready_i = 1'b0;
    logic [7:0]  axi_bid_i = '0, axi_rid_i = '0;
    logic [1:0]  axi_bresp_i = '0, axi_rresp_i = '0;
    logic        axi_bvalid_i = 1'b0, axi_rvalid_i = 1'b0, axi_rlast_i = 1'b0;
    logic [31:0] axi_rdata_i = '0;

    axi_burst_master dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready),
        .done_o(done_o), .err_o(err_o),
        .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
        .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o), .axi_awlock_o(axi_awlock_o),
        .axi_awcache_o(axi_awcache_o), .axi_awprot_o(axi_awprot_o), .axi_awqos_o(axi_awqos_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
        .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i),
        .axi_bready_o(axi_bready_o),
        .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
        .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o), .axi_arlock_o(axi_arlock_o),
        .axi_arcache_o(axi_arcache_o), .axi_arprot_o(axi_arprot_o), .axi_arqos_o(axi_arqos_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] slv_mem [int];
    logic [31:0] wq [$];
    logic [31:0] exp_rd [$];
    logic        exp_done [$];
    logic [23:0] exp_aw [$];
    logic [23:0] exp_ar [$];

    int k_bresp = 0, k_rerr = -1, k_rlast = 0;
    bit rd_tog = 1'b0;

    localparam logic [17:0] CONST_FIELDS = {3'd2, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event seen with nothing expected", nm);
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL timeout_%s: wait bound expired", nm);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Monitor: every DUT-presented event pops its expectation.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done_o) begin
                    chk("cmd_ready_at_done", 64'(cmd_ready_o), 64'd0);
                    if (exp_done.size() == 0) unexpected("done");
                    else chk("err", 64'(err_o), 64'(exp_done.pop_front()));
                end
                if (rd_valid_o && rd_ready) begin
                    if (exp_rd.size() == 0) unexpected("rd_beat");
                    else chk("rd_data", 64'(rd_data_o), 64'(exp_rd.pop_front()));
                end
                if (axi_awvalid_o && axi_awready_i) begin
                    if (exp_aw.size() == 0) unexpected("aw");
                    else chk("aw_addr_len", 64'({axi_awaddr_o, axi_awlen_o}), 64'(exp_aw.pop_front()));
                    chk("aw_const", 64'({axi_awsize_o, axi_awburst_o, axi_awlock_o, axi_awcache_o,
                                         axi_awprot_o, axi_awqos_o}), 64'(CONST_FIELDS));
                end
                if (axi_arvalid_o && axi_arready_i) begin
                    if (exp_ar.size() == 0) unexpected("ar");
                    else chk("ar_addr_len", 64'({axi_araddr_o, axi_arlen_o}), 64'(exp_ar.pop_front()));
                    chk("ar_const", 64'({axi_arsize_o, axi_arburst_o, axi_arlock_o, axi_arcache_o,
                                         axi_arprot_o, axi_arqos_o}), 64'(CONST_FIELDS));
                end
            end
        end
    end

    // Write-data source and read-data sink.
    initial begin : streams
        forever begin
            @(negedge clk);
            if (wr_valid && wr_ready_o && wq.size() > 0) void'(wq.pop_front());
            @(posedge clk);
            #1;
            if (wq.size() > 0 && ($urandom % 4 != 0)) begin
                wr_valid = 1'b1;
                wr_data  = wq[0];
            end else begin
                wr_valid = 1'b0;
            end
            rd_ready = rd_tog ? ~rd_ready : ($urandom % 4 != 0);
        end
    end

    // AXI RAM responder with random ready/valid gaps and injectable responses.
    initial begin : slave
        int waddr, wlen, wbeat, raddr, rbeat, rl, re, idx;
        bit w_act, b_pend, r_act, hs_r;
        logic [1:0] bresp;
        waddr = 0; wlen = 0; wbeat = 0; raddr = 0; rbeat = 0; rl = 0; re = -1;
        w_act = 0; b_pend = 0; r_act = 0; hs_r = 0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            hs_r = 1'b0;
            if (!rst_n) begin
                w_act = 0; b_pend = 0; r_act = 0;
            end else begin
                if (axi_awvalid_o && axi_awready_i) begin
                    waddr = int'(axi_awaddr_o) >> 2;
                    wlen  = int'(axi_awlen_o);
                    wbeat = 0;
                    w_act = 1'b1;
                    bresp = 2'(k_bresp);
                end
                if (axi_wvalid_o && axi_wready_i && w_act) begin
                    slv_mem[waddr + wbeat] = axi_wdata_o;
                    chk("wlast", 64'(axi_wlast_o), 64'(wbeat == wlen));
                    chk("wstrb", 64'(axi_wstrb_o), 64'hF);
                    if (wbeat == wlen) begin
                        w_act  = 1'b0;
                        b_pend = 1'b1;
                    end
                    wbeat++;
                end
                if (axi_bvalid_i && axi_bready_o) b_pend = 1'b0;
                if (axi_arvalid_o && axi_arready_i) begin
                    raddr = int'(axi_araddr_o) >> 2;
                    rbeat = 0;
                    rl    = k_rlast;
                    re    = k_rerr;
                    r_act = 1'b1;
                end else if (axi_rvalid_i && axi_rready_o) begin
                    hs_r = 1'b1;
                    if (axi_rlast_i) r_act = 1'b0;
                    rbeat++;
                end
            end
            @(posedge clk);
            #1;
            axi_awready_i = ($urandom % 3 == 0);
            axi_arready_i = ($urandom % 3 == 0);
            axi_wready_i  = ($urandom % 3 != 0);
            axi_bvalid_i  = b_pend;
            axi_bresp_i   = b_pend ? bresp : 2'b00;
            if (r_act && axi_rvalid_i && !hs_r) begin
                // hold the presented beat until it is taken
            end else if (r_act && ($urandom % 4 != 0)) begin
                idx          = raddr + rbeat;
                axi_rvalid_i = 1'b1;
                axi_rdata_i  = slv_mem.exists(idx) ? slv_mem[idx] : 32'h0;
                axi_rresp_i  = (rbeat == re) ? 2'b10 : 2'b00;
                axi_rlast_i  = (rbeat == rl);
            end else begin
                axi_rvalid_i = 1'b0;
                axi_rlast_i  = 1'b0;
            end
        end
    end

    task automatic send_cmd(input bit we, input logic [15:0] addr, input int len);
        int n = 0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        forever begin
            @(negedge clk);
            if (cmd_ready_o) break;
            n++;
            if (n > 2000) timeout("cmd_accept");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_len   = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            if (done_o) break;
            n++;
            if (n > 3000) timeout("done");
        end
    endtask

    // Reference model: word-addressed memory plus the burst rules for data count and error.
    task automatic issue(input bit we, input logic [15:0] addr, input int len, input int bresp,
                         input int rerr, input int rlast_at, input bit tog, input logic [31:0] dbase);
        int w0 = int'(addr) >> 2;
        int nb;
        logic e;
        logic [31:0] d;
        k_bresp = bresp;
        k_rerr  = rerr;
        k_rlast = rlast_at;
        rd_tog  = tog;
        if (we) begin
            exp_aw.push_back({addr & 16'hFFFC, 8'(len)});
            for (int i = 0; i <= len; i++) begin
                d = (dbase != 0) ? dbase + 32'(i) : $urandom;
                ref_mem[w0 + i] = d;
                wq.push_back(d);
            end
            exp_done.push_back(bresp != 0);
        end else begin
            exp_ar.push_back({addr & 16'hFFFC, 8'(len)});
`ifdef AXI_MASTER_RLAST_CHECK_EN
            nb = ((rlast_at < len) ? rlast_at : len) + 1;
            e  = (rlast_at != len);
`else
            nb = rlast_at + 1;
            e  = 1'b0;
`endif
            for (int i = 0; i < nb; i++) begin
                exp_rd.push_back(ref_mem.exists(w0 + i) ? ref_mem[w0 + i] : 32'h0);
                if (i == rerr) e = 1'b1;
            end
            exp_done.push_back(e);
        end
        send_cmd(we, addr, len);
        wait_done();
    endtask

    initial begin : main
        int len, rr, rlst;
        bit we;
        logic [15:0] a;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({cmd_ready_o, done_o, err_o, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o,
                               axi_bready_o, axi_rready_o, rd_valid_o, wr_ready_o}), 64'd0);
        chk("reset_latch", 64'({axi_awaddr_o, axi_awlen_o}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(cmd_ready_o), 64'd1);

        issue(1'b1, 16'h0100, 3, 0, -1, 3, 1'b0, 32'hA0);
        issue(1'b0, 16'h0100, 3, 0, -1, 3, 1'b1, 32'h0);
        issue(1'b1, 16'h0103, 0, 2, -1, 0, 1'b0, 32'hB0);
        issue(1'b0, 16'h0108, 1, 0, 0, 1, 1'b0, 32'h0);
        @(negedge clk);
        chk("cmd_ready_after_done", 64'(cmd_ready_o), 64'd1);
        issue(1'b0, 16'h0100, 3, 0, -1, 1, 1'b0, 32'h0);
`ifdef AXI_MASTER_RLAST_CHECK_EN
        issue(1'b0, 16'h0104, 1, 0, -1, 3, 1'b0, 32'h0);
`endif

        for (int t = 0; t < 40; t++) begin
            we  = 1'($urandom % 2);
            a   = 16'h0100 + 16'($urandom_range(0, 63));
            len = $urandom_range(0, 7);
            if (we) begin
                issue(1'b1, a, len, ($urandom % 2 != 0) ? 0 : $urandom_range(1, 3), -1, len, 1'b0, 32'h0);
            end else begin
                rr   = ($urandom % 4 == 0) ? $urandom_range(0, len) : -1;
                rlst = ($urandom % 4 == 0) ? $urandom_range(0, len) : len;
                issue(1'b0, a, len, 0, rr, rlst, 1'($urandom % 2), 32'h0);
            end
        end

        // Reset in the middle of a write data phase.
        k_bresp = 0;
        for (int i = 0; i < 8; i++) wq.push_back($urandom);
        exp_aw.push_back({16'h0800, 8'd7});
        send_cmd(1'b1, 16'h0800, 7);
        begin
            int n = 0;
            forever begin
                @(negedge clk);
                if (axi_wvalid_o) break;
                n++;
                if (n > 500) timeout("wvalid");
            end
        end
        rst_n = 1'b0;
        #1;
        chk("valids_in_reset", 64'({axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}), 64'd0);
        wq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_mid_reset", 64'(cmd_ready_o), 64'd1);
        repeat (6) begin
            @(negedge clk);
            chk("no_done_after_reset", 64'(done_o), 64'd0);
        end

        issue(1'b1, 16'h0120, 2, 0, -1, 2, 1'b0, 32'hC0);
        issue(1'b0, 16'h0120, 2, 0, -1, 2, 1'b0, 32'h0);

        repeat (4) @(negedge clk);
        chk("left_rd", 64'(exp_rd.size()), 64'd0);
        chk("left_done", 64'(exp_done.size()), 64'd0);
        chk("left_aw_ar", 64'(exp_aw.size() + exp_ar.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
